// File: rtl/bola_inimiga_ctrl.sv
// Enemy projectile controller: launch scheduling, downward flight, ship hit detection and life count.
// Optional macro BOLA_INIMIGA_MIRA_EN: projectile steers 1 px per tick toward the ship centre.
module bola_inimiga_ctrl #(
    parameter int TICK_DIV        = 833333,
    parameter int COOLDOWN        = 90,
    parameter int VEL             = 4,
    parameter int RAIO            = 5,
    parameter int LARGURA_INIMIGO = 40,
    parameter int ALTURA_INIMIGO  = 30,
    parameter int LARGURA_NAVE    = 45,
    parameter int ALTURA_NAVE     = 20,
    parameter int Y_MAX           = 480,
    parameter int VIDAS_INI       = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic [9:0] x_inimigo,
    input  logic [9:0] y_inimigo,
    input  logic       inimigo_vivo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] raio,
    output logic       ativa,
    output logic       acertou_nave,
    output logic [1:0] vidas,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ESPERA,
        VOANDO,
        ACERTO
    } estado_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COOL_MAX = CW'(COOLDOWN - 1);

    localparam logic [10:0] RAIO_W    = 11'(RAIO);
    localparam logic [10:0] VEL_W     = 11'(VEL);
    localparam logic [10:0] YMAX_W    = 11'(Y_MAX);
    localparam logic [10:0] MEIO_INI  = 11'(LARGURA_INIMIGO / 2);
    localparam logic [10:0] ALT_INI   = 11'(ALTURA_INIMIGO);
    localparam logic [10:0] LARG_NAVE = 11'(LARGURA_NAVE);
    localparam logic [10:0] ALT_NAVE  = 11'(ALTURA_NAVE);
    localparam logic [1:0]  VIDAS_RST = 2'(VIDAS_INI);

    estado_t       estado_q, estado_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    vidas_q, vidas_d;
    logic          game_over_q, game_over_d;

    logic          tick;
    logic [10:0]   lanc_x, lanc_y;
    logic [10:0]   x_voo, y_next;
    logic          hit;

    // Saturate an 11-bit result into the 10-bit screen range instead of wrapping.
    function automatic logic [9:0] sat10(input logic [10:0] v);
        return v[10] ? 10'h3FF : v[9:0];
    endfunction

    always_comb begin
        lanc_x = {1'b0, x_inimigo} + MEIO_INI;
        lanc_y = {1'b0, y_inimigo} + ALT_INI + RAIO_W;
        y_next = {1'b0, y_q} + VEL_W;
    end

`ifdef BOLA_INIMIGA_MIRA_EN
    localparam logic [10:0] MEIO_NAVE = 11'(LARGURA_NAVE / 2);
    localparam logic [10:0] X_MAX_W   = 11'(639 - RAIO);

    logic [10:0] alvo;
    logic [10:0] x_passo;

    always_comb begin
        alvo = {1'b0, x_nave} + MEIO_NAVE;
        if ({1'b0, x_q} < alvo) begin
            x_passo = {1'b0, x_q} + 11'd1;
        end else if ({1'b0, x_q} > alvo) begin
            x_passo = {1'b0, x_q} - 11'd1;
        end else begin
            x_passo = {1'b0, x_q};
        end
        if (x_passo < RAIO_W) begin
            x_voo = RAIO_W;
        end else if (x_passo > X_MAX_W) begin
            x_voo = X_MAX_W;
        end else begin
            x_voo = x_passo;
        end
    end
`else
    always_comb begin
        x_voo = {1'b0, x_q};
    end
`endif

    // Hit test uses the post-move position so a tick that enters the box is the hit tick.
    always_comb begin
        hit = (x_voo + RAIO_W >= {1'b0, x_nave}) &&
              (x_voo <= {1'b0, x_nave} + LARG_NAVE + RAIO_W) &&
              (y_next + RAIO_W >= {1'b0, y_nave}) &&
              (y_next <= {1'b0, y_nave} + ALT_NAVE);
    end

    always_comb begin
        estado_d   = estado_q;
        tick_cnt_d = tick_cnt_q;
        cool_d     = cool_q;
        x_d        = x_q;
        y_d        = y_q;
        vidas_d    = vidas_q;
        tick       = 1'b0;

        if (!pausa) begin
            tick       = (tick_cnt_q == TICK_MAX);
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

            unique case (estado_q)
                ESPERA: begin
                    if (!inimigo_vivo) begin
                        cool_d = '0;
                    end else if (tick && !game_over_q) begin
                        if (cool_q == COOL_MAX) begin
                            cool_d   = '0;
                            x_d      = sat10(lanc_x);
                            y_d      = sat10(lanc_y);
                            estado_d = VOANDO;
                        end else begin
                            cool_d = cool_q + CW'(1);
                        end
                    end
                end
                VOANDO: begin
                    if (tick) begin
                        x_d = sat10(x_voo);
                        if (hit) begin
                            y_d      = sat10(y_next);
                            estado_d = ACERTO;
                        end else if (y_next + RAIO_W > YMAX_W) begin
                            x_d      = '0;
                            y_d      = '0;
                            estado_d = ESPERA;
                        end else begin
                            y_d = sat10(y_next);
                        end
                    end
                end
                ACERTO: begin
                    vidas_d  = (vidas_q != 2'd0) ? vidas_q - 2'd1 : 2'd0;
                    x_d      = '0;
                    y_d      = '0;
                    estado_d = ESPERA;
                end
                default: begin
                    estado_d = ESPERA;
                end
            endcase
        end

        // Restart wins over pause.
        if (reiniciarJogo) begin
            estado_d   = ESPERA;
            tick_cnt_d = '0;
            cool_d     = '0;
            x_d        = '0;
            y_d        = '0;
            vidas_d    = VIDAS_RST;
        end

        game_over_d = (vidas_d == 2'd0);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado_q    <= ESPERA;
            tick_cnt_q  <= '0;
            cool_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            vidas_q     <= VIDAS_RST;
            game_over_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            tick_cnt_q  <= tick_cnt_d;
            cool_q      <= cool_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vidas_q     <= vidas_d;
            game_over_q <= game_over_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign raio         = 10'(RAIO);
    assign ativa        = (estado_q == VOANDO);
    assign acertou_nave = (estado_q == ACERTO) && !pausa;
    assign vidas        = vidas_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_bola_inimiga_ctrl.sv
// Directed bench for bola_inimiga_ctrl with a fast tick (TICK_DIV=4, COOLDOWN=2).
module tb_bola_inimiga_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       pausa = 1'b0;
    logic       reiniciarJogo = 1'b0;
    logic [9:0] x_inimigo = '0;
    logic [9:0] y_inimigo = '0;
    logic       inimigo_vivo = 1'b1;
    logic [9:0] x_nave = '0;
    logic [9:0] y_nave = '0;
    logic [9:0] x, y, raio;
    logic       ativa, acertou_nave, game_over;
    logic [1:0] vidas;

    int pass_cnt = 0;
    int total_cnt = 0;

    bola_inimiga_ctrl #(
        .TICK_DIV(4),
        .COOLDOWN(2)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .pausa        (pausa),
        .reiniciarJogo(reiniciarJogo),
        .x_inimigo    (x_inimigo),
        .y_inimigo    (y_inimigo),
        .inimigo_vivo (inimigo_vivo),
        .x_nave       (x_nave),
        .y_nave       (y_nave),
        .x            (x),
        .y            (y),
        .raio         (raio),
        .ativa        (ativa),
        .acertou_nave (acertou_nave),
        .vidas        (vidas),
        .game_over    (game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int xi, yi, xn, yn;
        int ex, ey;
        int eflight;
        int ehit;
        int eyend;
        int evidas;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic wait_ativa(input logic lvl, input int bound, output int n);
        n = 0;
        while (ativa !== lvl && n < bound) begin
            step(1);
            n++;
        end
        if (ativa !== lvl) check("wait_ativa_timeout", int'(ativa), int'(lvl));
    endtask

    initial begin
        int  n;
        logic ever;

        vecs[0] = '{20, 40,  20, 400,  40, 75, 320, 1, 395, 2};
        vecs[1] = '{20, 40, 300, 400,  40, 75, 404, 0,   0, 3};
        vecs[2] = '{100, 0,  60, 300, 120, 35, 444, 0,   0, 3};
        vecs[3] = '{90,  0,  60, 300, 110, 35, 260, 1, 295, 2};
        vecs[4] = '{20, 40,  45, 400,  40, 75, 320, 1, 395, 2};
        vecs[5] = '{20, 40,  46, 400,  40, 75, 404, 0,   0, 3};
        vecs[6] = '{20, 40,  20,  59,  40, 75,   4, 1,  79, 2};
        vecs[7] = '{20, 40,  20,  50,  40, 75, 404, 0,   0, 3};

        @(negedge CLOCK_50);
        x_inimigo = 10'd20; y_inimigo = 10'd40; x_nave = 10'd20; y_nave = 10'd400;
        do_reset();
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_ativa", ativa, 0);
        check("rst_acertou", acertou_nave, 0);
        check("rst_vidas", vidas, 3);
        check("rst_game_over", game_over, 0);
        check("raio", raio, 5);

        for (int i = 0; i < 8; i++) begin
            x_inimigo = 10'(vecs[i].xi); y_inimigo = 10'(vecs[i].yi);
            x_nave    = 10'(vecs[i].xn); y_nave    = 10'(vecs[i].yn);
            do_reset();
            wait_ativa(1'b1, 40, n);
            check($sformatf("v%0d_launch_cycles", i), n, 8);
            check($sformatf("v%0d_launch_x", i), x, vecs[i].ex);
            check($sformatf("v%0d_launch_y", i), y, vecs[i].ey);
            wait_ativa(1'b0, 600, n);
            check($sformatf("v%0d_flight_cycles", i), n, vecs[i].eflight);
            check($sformatf("v%0d_hit_pulse", i), acertou_nave, vecs[i].ehit);
            check($sformatf("v%0d_end_y", i), y, vecs[i].eyend);
            step(1);
            check($sformatf("v%0d_pulse_off", i), acertou_nave, 0);
            check($sformatf("v%0d_vidas", i), vidas, vecs[i].evidas);
            check($sformatf("v%0d_y_cleared", i), y, 0);
            wait_ativa(1'b1, 40, n);
            check($sformatf("v%0d_relaunch_cycles", i), n, 7);
        end

        // Enemy dead holds the cooldown; launch comes two ticks after it revives.
        x_nave = 10'd20; y_nave = 10'd400;
        inimigo_vivo = 1'b0;
        do_reset();
        ever = 1'b0;
        repeat (40) begin
            step(1);
            ever |= ativa;
        end
        check("dead_no_launch", ever, 0);
        inimigo_vivo = 1'b1;
        wait_ativa(1'b1, 40, n);
        check("revive_launch_cycles", n, 8);

        // Three hits exhaust lives; game over blocks further launches.
        do_reset();
        for (int h = 0; h < 3; h++) begin
            wait_ativa(1'b1, 40, n);
            wait_ativa(1'b0, 400, n);
            check($sformatf("hit%0d_pulse", h), acertou_nave, 1);
        end
        step(1);
        check("go_vidas", vidas, 0);
        check("go_flag", game_over, 1);
        ever = 1'b0;
        repeat (80) begin
            step(1);
            ever |= ativa;
        end
        check("go_no_launch", ever, 0);
        check("go_vidas_hold", vidas, 0);

        // Pause mid-flight freezes everything, remaining timing unchanged.
        do_reset();
        wait_ativa(1'b1, 40, n);
        step(100);
        check("pre_pause_y", y, 175);
        pausa = 1'b1;
        ever = 1'b0;
        repeat (50) begin
            step(1);
            ever |= acertou_nave;
        end
        check("pause_y", y, 175);
        check("pause_x", x, 40);
        check("pause_ativa", ativa, 1);
        check("pause_no_pulse", ever, 0);
        pausa = 1'b0;
        wait_ativa(1'b0, 400, n);
        check("resume_cycles", n, 220);
        check("resume_hit", acertou_nave, 1);
        step(1);
        check("resume_vidas", vidas, 2);

        // Restart together with pause still restarts.
        wait_ativa(1'b1, 40, n);
        step(10);
        pausa = 1'b1;
        reiniciarJogo = 1'b1;
        step(1);
        check("restart_ativa", ativa, 0);
        check("restart_y", y, 0);
        check("restart_vidas", vidas, 3);
        check("restart_game_over", game_over, 0);
        pausa = 1'b0;
        reiniciarJogo = 1'b0;
        wait_ativa(1'b1, 40, n);
        check("restart_launch_cycles", n, 8);

        // Asynchronous reset between clock edges mid-flight.
        wait_ativa(1'b0, 400, n);
        step(1);
        check("ar_pre_vidas", vidas, 2);
        wait_ativa(1'b1, 40, n);
        step(20);
        #2 reset = 1'b0;
        #1;
        check("ar_x", x, 0);
        check("ar_y", y, 0);
        check("ar_ativa", ativa, 0);
        check("ar_vidas", vidas, 3);
        @(negedge CLOCK_50);
        reset = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
